cplx_trivial_rot_pipe: RTL and testbench

//  Pipelined, parametrised trivial-twiddle rotator for the FFT datapath: multiplies a packed

---
 rtl/cplx_trivial_rot_pipe.sv | 112 +++++++++++
 tb/tb_cplx_trivial_rot_pipe.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cplx_trivial_rot_pipe.sv
// Trivial-twiddle complex rotator (x1, x-1, +j, -j, conj) built from swap/negate only,
// followed by an elastic valid/ready register pipeline and a saturating negation-event counter.
module cplx_trivial_rot_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int PIPE_DEPTH = 2,
    parameter int SAT_EN     = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [2*DATA_WIDTH-1:0]   A,
    input  logic [2:0]                TYPESEL,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [2*DATA_WIDTH-1:0]   R,
    output logic                      R_SAT,
    input  logic                      CNT_CLR,
    output logic [CNT_WIDTH-1:0]      SAT_CNT
);

    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MOST_POS = ~MOST_NEG;

    function automatic logic [W-1:0] neg(input logic [W-1:0] x);
        if (x == MOST_NEG) begin
            return (SAT_EN != 0) ? MOST_POS : MOST_NEG;
        end
        return -x;
    endfunction

    logic [W-1:0] a_re;
    logic [W-1:0] a_im;
    logic [W-1:0] s_re;
    logic [W-1:0] s_im;
    logic [W-1:0] r_re;
    logic [W-1:0] r_im;
    logic         sat_evt;

    always_comb begin
        a_re    = A[2*W-1:W];
        a_im    = A[W-1:0];
        s_re    = TYPESEL[2] ? a_im : a_re;
        s_im    = TYPESEL[2] ? a_re : a_im;
        r_re    = TYPESEL[1] ? neg(s_re) : s_re;
        r_im    = TYPESEL[0] ? neg(s_im) : s_im;
        // Flagged in both SAT_EN modes: the event is the attempt, not the clamp.
        sat_evt = (TYPESEL[1] && (s_re == MOST_NEG)) || (TYPESEL[0] && (s_im == MOST_NEG));
    end

    logic [PIPE_DEPTH-1:0] v;
    logic [PIPE_DEPTH-1:0] adv;
    logic [PIPE_DEPTH-1:0] s;
    logic [2*W-1:0]        d [PIPE_DEPTH];

    // Stage k may advance unless it and every stage downstream of it are full and stalled.
    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_adv
        assign adv[k] = OUT_READY | ~(&v[PIPE_DEPTH-1:k]);
    end

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    v[0] <= 1'b0;
                    d[0] <= '0;
                    s[0] <= 1'b0;
                end else if (adv[0]) begin
                    v[0] <= IN_VALID;
                    d[0] <= {r_re, r_im};
                    s[0] <= sat_evt;
                end
            end
        end else begin : g_tail
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    v[k] <= 1'b0;
                    d[k] <= '0;
                    s[k] <= 1'b0;
                end else if (adv[k]) begin
                    v[k] <= v[k-1];
                    d[k] <= d[k-1];
                    s[k] <= s[k-1];
                end
            end
        end
    end

    logic                 accept;
    logic [CNT_WIDTH-1:0] cnt;

    assign accept = IN_VALID & adv[0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (CNT_CLR) begin
            cnt <= '0;
        end else if (accept && sat_evt && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign IN_READY  = adv[0];
    assign OUT_VALID = v[PIPE_DEPTH-1];
    assign R         = d[PIPE_DEPTH-1];
    assign R_SAT     = s[PIPE_DEPTH-1];
    assign SAT_CNT   = cnt;

endmodule

// File: tb/tb_cplx_trivial_rot_pipe.sv
// Bench for cplx_trivial_rot_pipe: four instances (PIPE_DEPTH 1..4, SAT_EN=0 on depth 3),
// each tracked by a queue-based reference model, plus directed hand-computed vectors.
module tb_cplx_trivial_rot_pipe;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iv        [N];
    logic        in_ready  [N];
    logic [31:0] a_in      [N];
    logic [2:0]  ts        [N];
    logic        out_valid [N];
    logic        ordy      [N];
    logic [31:0] r_out     [N];
    logic        r_sat     [N];
    logic        clr       [N];
    logic [3:0]  sat_cnt   [N];
    int          pending   [N];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        cplx_trivial_rot_pipe #(
            .DATA_WIDTH (16),
            .PIPE_DEPTH (g + 1),
            .SAT_EN     ((g == 2) ? 0 : 1),
            .CNT_WIDTH  (4)
        ) u_dut (
            .CLK       (clk),
            .RST       (rst),
            .IN_VALID  (iv[g]),
            .IN_READY  (in_ready[g]),
            .A         (a_in[g]),
            .TYPESEL   (ts[g]),
            .OUT_VALID (out_valid[g]),
            .OUT_READY (ordy[g]),
            .R         (r_out[g]),
            .R_SAT     (r_sat[g]),
            .CNT_CLR   (clr[g]),
            .SAT_CNT   (sat_cnt[g])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: signed arithmetic on the two components; result is {event, re, im}.
    function automatic logic [32:0] ref_rot(input logic [31:0] av, input logic [2:0] t, input bit sat);
        int re;
        int im;
        int x;
        int y;
        bit ev;
        re = int'($signed(av[31:16]));
        im = int'($signed(av[15:0]));
        x  = t[2] ? im : re;
        y  = t[2] ? re : im;
        ev = (t[1] && x == -32768) || (t[0] && y == -32768);
        if (t[1]) x = -x;
        if (t[0]) y = -y;
        if (x == 32768) x = sat ? 32767 : -32768;
        if (y == 32768) y = sat ? 32767 : -32768;
        return {ev, x[15:0], y[15:0]};
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_chk
        logic [32:0] q [$];
        logic [32:0] held;
        logic [32:0] e;
        logic [3:0]  cnt_m;
        logic        stall_prev;
        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                cnt_m      = '0;
                stall_prev = 1'b0;
            end else begin
                chk($sformatf("in_ready%0d", g), 64'(in_ready[g]),
                    64'(ordy[g] || (q.size() < g + 1)));
                chk($sformatf("sat_cnt%0d", g), 64'(sat_cnt[g]), 64'(cnt_m));
                if (stall_prev) begin
                    chk($sformatf("hold%0d", g), {out_valid[g], r_sat[g], r_out[g]}, {1'b1, held});
                end
                if (out_valid[g] && ordy[g]) begin
                    if (q.size() == 0) begin
                        chk($sformatf("unexpected_out%0d", g), {r_sat[g], r_out[g]}, 64'hDEAD);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("out%0d", g), {r_sat[g], r_out[g]}, e);
                    end
                end
                stall_prev = out_valid[g] && !ordy[g];
                held       = {r_sat[g], r_out[g]};
                if (clr[g]) begin
                    cnt_m = '0;
                end
                if (iv[g] && in_ready[g]) begin
                    e = ref_rot(a_in[g], ts[g], g != 2);
                    q.push_back(e);
                    if (!clr[g] && e[32] && cnt_m != 4'hF) cnt_m = cnt_m + 4'd1;
                end
            end
            pending[g] = q.size();
        end
    end

    task automatic send_one(input int idx, input logic [31:0] av, input logic [2:0] t,
                            output logic [31:0] r, output logic rs, output int lat);
        int n;
        iv[idx]   = 1'b1;
        a_in[idx] = av;
        ts[idx]   = t;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready[idx] && n < 20);
        @(posedge clk);
        #1;
        iv[idx] = 1'b0;
        lat = 0;
        r   = '0;
        rs  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (out_valid[idx]) begin
                r  = r_out[idx];
                rs = r_sat[idx];
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] vec_a   [5];
    logic [2:0]  vec_t   [5];
    logic [31:0] vec_r   [5];
    logic [31:0] outs    [8];
    logic [31:0] r;
    logic        rs;
    int          lat;
    int          k;
    int          got;
    int          n;
    logic        saw_low;
    logic        stray;

    initial begin
        for (int i = 0; i < N; i++) begin
            iv[i] = 1'b0; a_in[i] = '0; ts[i] = '0; ordy[i] = 1'b1; clr[i] = 1'b0;
        end
        #1 rst = 1'b1;
        #2;
        for (int i = 0; i < N; i++) begin
            chk("reset_out_valid", 64'(out_valid[i]), 64'd0);
            chk("reset_r", {r_sat[i], r_out[i]}, 64'd0);
            chk("reset_sat_cnt", 64'(sat_cnt[i]), 64'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(in_ready[1]), 64'd1);
        @(posedge clk);
        #1;

        chk("model_jrot", ref_rot(32'h1234_5678, 3'b110, 1'b1), 33'h0_A988_1234);
        chk("model_sat", ref_rot(32'h8000_0001, 3'b011, 1'b1), 33'h1_7FFF_FFFF);
        chk("model_wrap", ref_rot(32'h8000_0001, 3'b011, 1'b0), 33'h1_8000_FFFF);
        chk("model_swap", ref_rot(32'h0000_8000, 3'b100, 1'b1), 33'h0_8000_0000);

        vec_a = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
        vec_t = '{3'b000, 3'b011, 3'b001, 3'b110, 3'b101};
        vec_r = '{32'h1234_5678, 32'hEDCC_A988, 32'h1234_A988, 32'hA988_1234, 32'h5678_EDCC};
        for (int i = 0; i < 5; i++) begin
            send_one(1, vec_a[i], vec_t[i], r, rs, lat);
            chk($sformatf("op%0d_r", i), 64'(r), 64'(vec_r[i]));
            chk($sformatf("op%0d_lat", i), 64'(lat), 64'd2);
        end

        chk("cnt_before_sat", 64'(sat_cnt[1]), 64'd0);
        send_one(1, 32'h8000_0001, 3'b011, r, rs, lat);
        chk("sat_r", {rs, r}, {1'b1, 32'h7FFF_FFFF});
        chk("sat_cnt_one", 64'(sat_cnt[1]), 64'd1);
        send_one(2, 32'h8000_0001, 3'b011, r, rs, lat);
        chk("wrap_r", {rs, r}, {1'b1, 32'h8000_FFFF});
        chk("wrap_lat", 64'(lat), 64'd3);

        k = 0; got = 0; saw_low = 1'b0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            ordy[1] = !(c >= 3 && c <= 7);
            iv[1]   = (k < 8);
            a_in[1] = 32'h1111_0000 + 32'(k);
            ts[1]   = 3'b000;
            @(negedge clk);
            if (!in_ready[1]) saw_low = 1'b1;
            if (iv[1] && in_ready[1]) k++;
            if (out_valid[1] && ordy[1]) begin
                outs[got] = r_out[1];
                got++;
            end
            @(posedge clk);
            #1;
        end
        iv[1] = 1'b0; ordy[1] = 1'b1;
        chk("stream_count", 64'(got), 64'd8);
        chk("stream_ready_dropped", 64'(saw_low), 64'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("stream_out%0d", i), 64'(outs[i]), 64'(32'h1111_0000 + 32'(i)));
        end

        iv[0] = 1'b1; a_in[0] = 32'h8000_8000; ts[0] = 3'b011;
        n = 0;
        for (int c = 0; c < 60 && n < 20; c++) begin
            @(negedge clk);
            if (in_ready[0]) n++;
            @(posedge clk);
            #1;
        end
        iv[0] = 1'b0;
        @(negedge clk);
        chk("cnt_saturates", 64'(sat_cnt[0]), 64'd15);
        @(posedge clk);
        #1;
        iv[0] = 1'b1; clr[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0; clr[0] = 1'b0;
        @(negedge clk);
        chk("clr_priority", 64'(sat_cnt[0]), 64'd0);
        @(posedge clk);
        #1;

        ordy[1] = 1'b0; iv[1] = 1'b1; a_in[1] = 32'h8000_0001; ts[1] = 3'b011;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!in_ready[1]) break;
            @(posedge clk);
            #1;
        end
        chk("full_ready_low", 64'(in_ready[1]), 64'd0);
        chk("full_cnt", 64'(sat_cnt[1]), 64'd3);
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid[1]), 64'd0);
        chk("rst_r", {r_sat[1], r_out[1]}, 64'd0);
        chk("rst_cnt", 64'(sat_cnt[1]), 64'd0);
        iv[1] = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        ordy[1] = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(in_ready[1]), 64'd1);
        stray = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid[1]) stray = 1'b1;
        end
        chk("rst_no_stale", 64'(stray), 64'd0);
        @(posedge clk);
        #1;

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                iv[i]   = ($urandom_range(0, 3) != 0);
                a_in[i] = $urandom();
                if ($urandom_range(0, 3) == 0) a_in[i][31:16] = 16'h8000;
                if ($urandom_range(0, 3) == 0) a_in[i][15:0]  = 16'h8000;
                ts[i]   = 3'($urandom_range(0, 7));
                ordy[i] = ($urandom_range(0, 2) != 0);
                clr[i]  = ($urandom_range(0, 31) == 0);
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < N; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b1; clr[i] = 1'b0;
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("drained%0d", i), 64'(pending[i]), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
